// File: rtl/dmem_sized_wait_if.sv
// Request/response bus between the MEM stage and the sized data memory.
// The master drives a request (store/load, access size, extension mode,
// byte address, store data); the slave answers with ready/done/err and
// the load result.
interface dmem_sized_wait_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              write;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       data_out;

    modport master (
        output req, write, size, is_unsigned, address, data_in,
        input  ready, done, err, data_out
    );

    modport slave (
        input  req, write, size, is_unsigned, address, data_in,
        output ready, done, err, data_out
    );
endinterface

// File: rtl/dmem_sized_wait.sv
// Byte-addressed data memory with byte/half/word loads and stores and a
// programmable number of wait states between accept and done.
// Storage is DEPTH 32-bit words; the byte address aliases modulo 4*DEPTH.
// A request is accepted only while idle; the operation executes on the
// clock edge that enters the response state, where done/err/data_out are
// registered for exactly one cycle.
module dmem_sized_wait #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    dmem_sized_wait_if.slave  bus
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic       NO_WAIT   = (WAIT_STATES == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Sequential state
    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              write_r;
    logic [1:0]        size_r;
    logic              zext_r;
    logic [IDX_W+1:0]  addr_r;
    logic [31:0]       wdata_r;
    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       data_out_r;
    logic [31:0]       mem_r [DEPTH];

    // Request as seen by the execute logic
    logic              sel_write_s;
    logic [1:0]        sel_size_s;
    logic              sel_zext_s;
    logic [IDX_W+1:0]  sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        lane_s;
    logic              bad_s;
    logic [3:0]        be_s;
    logic [31:0]       wlanes_s;
    logic [31:0]       rword_s;
    logic [31:0]       load_s;
    logic              exec_s;

    // Address bits above the aliasing window carry no information.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_addr_hi
            logic unused_addr_hi_s;
            assign unused_addr_hi_s = ^bus.address[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    // Access is illegal for the reserved size or a misaligned half/word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lane[0];
            2'b10:   r = (lane != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/half out of a word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b00:   r = zext ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = zext ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // With no wait states the execute edge is the accept edge, so the
    // live bus fields are used there; otherwise the latched copy is used.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_write_s = bus.write;
            sel_size_s  = bus.size;
            sel_zext_s  = bus.is_unsigned;
            sel_addr_s  = bus.address[IDX_W+1:0];
            sel_wdata_s = bus.data_in;
        end else begin
            sel_write_s = write_r;
            sel_size_s  = size_r;
            sel_zext_s  = zext_r;
            sel_addr_s  = addr_r;
            sel_wdata_s = wdata_r;
        end
    end

    // Decode word index, lane, byte enables and replicated store lanes.
    always_comb begin
        idx_s    = sel_addr_s[IDX_W+1:2];
        lane_s   = sel_addr_s[1:0];
        bad_s    = misaligned(sel_size_s, lane_s);
        be_s     = 4'b0000;
        wlanes_s = 32'd0;
        case (sel_size_s)
            2'b00: begin
                be_s     = 4'b0001 << lane_s;
                wlanes_s = {4{sel_wdata_s[7:0]}};
            end
            2'b01: begin
                be_s     = lane_s[1] ? 4'b1100 : 4'b0011;
                wlanes_s = {2{sel_wdata_s[15:0]}};
            end
            2'b10: begin
                be_s     = 4'b1111;
                wlanes_s = sel_wdata_s;
            end
            default: begin
                be_s     = 4'b0000;
                wlanes_s = 32'd0;
            end
        endcase
        rword_s = mem_r[idx_s];
        load_s  = extract_load(rword_s, sel_size_s, lane_s, sel_zext_s);
    end

    // Execute strobe: the edge that moves the FSM into the response state.
    always_comb begin
        exec_s = ((state_r == ST_IDLE) && bus.req && NO_WAIT)
              || ((state_r == ST_WAIT) && (cnt_r == WAIT_LAST));
    end

    // Byte-enabled array write; a reset on the execute edge discards it.
    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset && exec_s && sel_write_s && !bad_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlanes_s[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            write_r    <= 1'b0;
            size_r     <= 2'b00;
            zext_r     <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            data_out_r <= 32'd0;
        end else begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            data_out_r <= 32'd0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req) begin
                        write_r <= bus.write;
                        size_r  <= bus.size;
                        zext_r  <= bus.is_unsigned;
                        addr_r  <= bus.address[IDX_W+1:0];
                        wdata_r <= bus.data_in;
                        ready_r <= 1'b0;
                        cnt_r   <= 4'd0;
                        if (NO_WAIT) begin
                            state_r    <= ST_RESP;
                            done_r     <= 1'b1;
                            err_r      <= bad_s;
                            data_out_r <= (!bad_s && !sel_write_s) ? load_s : 32'd0;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        state_r    <= ST_RESP;
                        done_r     <= 1'b1;
                        err_r      <= bad_s;
                        data_out_r <= (!bad_s && !sel_write_s) ? load_s : 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
    assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Bench for dmem_sized_wait: two instances (0 and 3 wait states) driven
// through their bus interfaces, checked against a byte-array model.
module tb_dmem_sized_wait;

    logic clk;
    int   checks;
    int   errors;

    logic        rst_v   [2];
    logic        req_v   [2];
    logic        wr_v    [2];
    logic [1:0]  sz_v    [2];
    logic        zx_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wd_v    [2];
    logic        ready_o [2];
    logic        done_o  [2];
    logic        err_o   [2];
    logic [31:0] dout_o  [2];

    logic [7:0] mem_m [2][1024];

    dmem_sized_wait_if #(.ADDR_W(32)) if0 ();
    dmem_sized_wait_if #(.ADDR_W(32)) if3 ();

    assign if0.req = req_v[0];   assign if3.req = req_v[1];
    assign if0.write = wr_v[0];  assign if3.write = wr_v[1];
    assign if0.size = sz_v[0];   assign if3.size = sz_v[1];
    assign if0.is_unsigned = zx_v[0]; assign if3.is_unsigned = zx_v[1];
    assign if0.address = addr_v[0];   assign if3.address = addr_v[1];
    assign if0.data_in = wd_v[0];     assign if3.data_in = wd_v[1];
    assign ready_o[0] = if0.ready; assign ready_o[1] = if3.ready;
    assign done_o[0]  = if0.done;  assign done_o[1]  = if3.done;
    assign err_o[0]   = if0.err;   assign err_o[1]   = if3.err;
    assign dout_o[0]  = if0.data_out; assign dout_o[1] = if3.data_out;

    dmem_sized_wait #(.DEPTH(256), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
        .SYS_clk(clk), .SYS_reset(rst_v[0]), .bus(if0));
    dmem_sized_wait #(.DEPTH(256), .WAIT_STATES(3), .ADDR_W(32)) dut3 (
        .SYS_clk(clk), .SYS_reset(rst_v[1]), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    task automatic model_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd);
        int base;
        base = int'(a % 1024);
        if (!exp_err(sz, a))
            for (int k = 0; k < nbytes(sz); k++) mem_m[d][base + k] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] model_load(input int d, input logic [1:0] sz,
                                               input logic zx, input logic [31:0] a);
        int base;
        logic [31:0] v;
        base = int'(a % 1024);
        if (exp_err(sz, a)) return 32'd0;
        v = 32'd0;
        for (int k = 0; k < nbytes(sz); k++) v = v | (32'(mem_m[d][base + k]) << (8*k));
        if (!zx && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (!zx && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // ---------------- bus driver ----------------
    // Issues one request, waits for done; returns result, latency (cycles
    // from accept edge to done), count of ready-low cycles, and whether the
    // cycle after done shows done low and ready high.
    task automatic do_op(input int d, input logic wr, input logic [1:0] sz, input logic zx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int low, output logic pulse_ok);
        int guard;
        wr_v[d] = wr; sz_v[d] = sz; zx_v[d] = zx; addr_v[d] = a; wd_v[d] = wd;
        req_v[d] = 1'b1;
        guard = 0;
        while (ready_o[d] !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        req_v[d] = 1'b0;
        wr_v[d] = 1'b0; sz_v[d] = 2'd0; addr_v[d] = 32'hFFFF_FFFF; wd_v[d] = 32'hFFFF_FFFF;
        lat = 1; low = 0;
        if (ready_o[d] === 1'b0) low++;
        while (done_o[d] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (ready_o[d] === 1'b0) low++;
        end
        rd = dout_o[d]; er = err_o[d];
        @(posedge clk); #1;
        pulse_ok = (done_o[d] === 1'b0) && (ready_o[d] === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++; if (ready_o[d] !== 1'b1) begin errors++; $display("FAIL reset_ready d%0d: got %b want 1", d, ready_o[d]); end
            checks++; if (done_o[d] !== 1'b0) begin errors++; $display("FAIL reset_done d%0d: got %b want 0", d, done_o[d]); end
            checks++; if (err_o[d] !== 1'b0) begin errors++; $display("FAIL reset_err d%0d: got %b want 0", d, err_o[d]); end
            checks++; if (dout_o[d] !== 32'd0) begin errors++; $display("FAIL reset_dout d%0d: got %h want 0", d, dout_o[d]); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; int low; logic pk;
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, rd, er, lat, low, pk);
        model_store(0, 2'd2, 32'h10, 32'h1122_3344);
        checks++; if (lat != 1) begin errors++; $display("FAIL sw_latency: got %0d want 1", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_resp: got err %b data %h want 0/0", er, rd); end
        checks++; if (!pk || low != 1) begin errors++; $display("FAIL sw_handshake: got pulse_ok %b low %0d want 1/1", pk, low); end
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL lw: got %h err %b want 11223344/0", rd, er); end
        checks++; if (lat != 1) begin errors++; $display("FAIL lw_latency: got %0d want 1", lat); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat; int low; logic pk;
        do_op(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, rd, er, lat, low, pk);
        model_store(0, 2'd0, 32'h11, 32'hAA);
        do_op(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL lbu: got %h want 000000aa", rd); end
        do_op(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb: got %h want ffffffaa", rd); end
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h1122_AA44) begin errors++; $display("FAIL lw_after_sb: got %h want 1122aa44", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat; int low; logic pk;
        do_op(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_8001, rd, er, lat, low, pk);
        model_store(0, 2'd1, 32'h12, 32'hFFFF_8001);
        do_op(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got %h want ffff8001", rd); end
        do_op(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got %h want 00008001", rd); end
        do_op(0, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, rd, er, lat, low, pk);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL lh_misaligned: got err %b data %h want 1/0", er, rd); end
        do_op(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000_5555, rd, er, lat, low, pk);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err %b want 1", er); end
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h8001_AA44) begin errors++; $display("FAIL lw_after_sh: got %h want 8001aa44", rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd; logic er; int lat; int low; logic pk;
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h4, 32'h0102_0304, rd, er, lat, low, pk);
        model_store(0, 2'd2, 32'h4, 32'h0102_0304);
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hDEAD_BEEF, rd, er, lat, low, pk);
        model_store(0, 2'd2, 32'h400, 32'hDEAD_BEEF);
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias: got %h want deadbeef", rd); end
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h6, 32'h7777_7777, rd, er, lat, low, pk);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL sw_misaligned: got err %b data %h want 1/0", er, rd); end
        do_op(0, 1'b1, 2'd3, 1'b0, 32'h4, 32'h6666_6666, rd, er, lat, low, pk);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL size_reserved: got err %b want 1", er); end
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h8000_0404, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL no_write_on_err: got %h want 01020304", rd); end
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic er; int lat; int low; logic pk;
        do_op(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D, rd, er, lat, low, pk);
        model_store(1, 2'd2, 32'h30, 32'hCAFE_F00D);
        checks++; if (lat != 4) begin errors++; $display("FAIL wait_latency: got %0d want 4", lat); end
        checks++; if (low != 4 || !pk) begin errors++; $display("FAIL wait_ready_low: got %0d pulse_ok %b want 4/1", low, pk); end
        do_op(1, 1'b0, 2'd0, 1'b0, 32'h33, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'hFFFF_FFCA || lat != 4) begin errors++; $display("FAIL wait_lb: got %h lat %0d want ffffffca/4", rd, lat); end
    endtask

    // Request held high across two ops; the second fields appear while busy.
    task automatic test_back_to_back();
        int ndone; int at0; int at1; logic [31:0] d0; logic [31:0] d1; int guard;
        ndone = 0; at0 = 0; at1 = 0; d0 = 32'hX; d1 = 32'hX;
        wr_v[1] = 1'b1; sz_v[1] = 2'd2; zx_v[1] = 1'b0; addr_v[1] = 32'h34; wd_v[1] = 32'h0BAD_C0DE;
        req_v[1] = 1'b1;
        guard = 0;
        while (ready_o[1] !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        wr_v[1] = 1'b0; addr_v[1] = 32'h34; wd_v[1] = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            if (done_o[1] === 1'b1) begin
                if (ndone == 0) begin at0 = c; d0 = dout_o[1]; end
                else begin at1 = c; d1 = dout_o[1]; end
                ndone++;
            end
            if (c == 9) req_v[1] = 1'b0;
            @(posedge clk); #1;
        end
        model_store(1, 2'd2, 32'h34, 32'h0BAD_C0DE);
        checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", ndone); end
        checks++; if (at0 != 4 || at1 != 9) begin errors++; $display("FAIL b2b_timing: got %0d,%0d want 4,9", at0, at1); end
        checks++; if (d0 !== 32'd0 || d1 !== 32'h0BAD_C0DE) begin errors++; $display("FAIL b2b_data: got %h,%h want 0,0badc0de", d0, d1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int low; logic pk; int guard;
        do_op(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, rd, er, lat, low, pk);
        model_store(1, 2'd2, 32'h20, 32'h1234_5678);
        wr_v[1] = 1'b1; sz_v[1] = 2'd2; addr_v[1] = 32'h20; wd_v[1] = 32'h5;
        req_v[1] = 1'b1;
        guard = 0;
        while (ready_o[1] !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        rst_v[1] = 1'b1;
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        checks++; if (ready_o[1] !== 1'b1 || done_o[1] !== 1'b0) begin errors++; $display("FAIL reset_mid: got ready %b done %b want 1/0", ready_o[1], done_o[1]); end
        do_op(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, low, pk);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL store_discarded: got %h want 12345678", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; int low; logic pk;
        logic [31:0] a; logic [31:0] wd; logic [1:0] sz; logic wr; logic zx; int d;
        for (int dd = 0; dd < 2; dd++)
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                do_op(dd, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4*w), wd, rd, er, lat, low, pk);
                model_store(dd, 2'd2, 32'h100 + 32'(4*w), wd);
            end
        for (int i = 0; i < 60; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            zx = 1'($urandom_range(0, 1));
            a  = (32'($urandom_range(0, 7)) << 29) | (32'($urandom_range(0, 63)) << 10)
               | (32'h100 + 32'($urandom_range(0, 63)));
            wd = $urandom;
            do_op(d, wr, sz, zx, a, wd, rd, er, lat, low, pk);
            checks++;
            if (er !== exp_err(sz, a) || rd !== (wr ? 32'd0 : model_load(d, sz, zx, a))
                || lat != ((d == 0) ? 1 : 4) || !pk) begin
                errors++;
                $display("FAIL random[%0d] d%0d wr%b sz%0d a=%h: got err %b data %h lat %0d want err %b data %h lat %0d",
                         i, d, wr, sz, a, er, rd, lat, exp_err(sz, a),
                         wr ? 32'd0 : model_load(d, sz, zx, a), (d == 0) ? 1 : 4);
            end
            if (wr) model_store(d, sz, a, wd);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; req_v[d] = 1'b0; wr_v[d] = 1'b0; sz_v[d] = 2'd0;
            zx_v[d] = 1'b0; addr_v[d] = 32'd0; wd_v[d] = 32'd0;
        end
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_alias();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
